// File: rtl/data_mem_dma_pkg.sv
// Shared encodings for the data-memory fill/copy engine.
package data_mem_dma_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Command opcodes; any opcode with bit 1 set is reserved and runs as a no-op.
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    COPY_RD = 3'd2,
    COPY_WR = 3'd3,
    FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/data_mem_dma_if.sv
// Core load/store path, engine command/status and the memory port, bundled.
interface data_mem_dma_if
  import data_mem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // Core side
  logic              CpuWriteEn;
  logic              CpuReadEn;
  logic [ADDR_W-1:0] CpuAddress;
  logic [DATA_W-1:0] CpuDataIn;
  logic [DATA_W-1:0] CpuDataOut;
  logic              CpuStall;
  // Engine command and status
  logic              Start;
  logic [1:0]        Op;
  logic [ADDR_W-1:0] SrcAddr;
  logic [ADDR_W-1:0] DstAddr;
  logic [ADDR_W-1:0] Len;
  logic [DATA_W-1:0] FillValue;
  logic              Busy;
  logic              Done;
  // Memory port
  logic              MemWriteEn;
  logic              MemReadEn;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemDataOut;
  logic [DATA_W-1:0] MemDataIn;

  modport slave (
    input  CpuWriteEn, CpuReadEn, CpuAddress, CpuDataIn,
    output CpuDataOut, CpuStall,
    input  Start, Op, SrcAddr, DstAddr, Len, FillValue,
    output Busy, Done,
    output MemWriteEn, MemReadEn, MemAddress, MemDataOut,
    input  MemDataIn
  );

  modport master (
    output CpuWriteEn, CpuReadEn, CpuAddress, CpuDataIn,
    input  CpuDataOut, CpuStall,
    output Start, Op, SrcAddr, DstAddr, Len, FillValue,
    input  Busy, Done,
    input  MemWriteEn, MemReadEn, MemAddress, MemDataOut,
    output MemDataIn
  );
endinterface

// File: rtl/data_mem_dma.sv
// Memory-port owner: passes core loads/stores through when idle and runs a
// byte-at-a-time FILL or COPY engine that takes the port over while busy.
module data_mem_dma
  import data_mem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic           Clk,
  input logic           Reset,
  data_mem_dma_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_latch;
  logic              w_cpu_req;

  assign w_cpu_req = bus.CpuWriteEn | bus.CpuReadEn;

  // State register; reset aborts any transfer immediately without a Done pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Address/count/data registers; addresses wrap naturally at 2**ADDR_W.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_fill  <= '0;
      r_latch <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_src  <= bus.SrcAddr;
            r_dst  <= bus.DstAddr;
            r_rem  <= bus.Len;
            r_fill <= bus.FillValue;
          end
        end
        FILL: begin
          r_dst <= r_dst + 1'b1;
          r_rem <= r_rem - 1'b1;
        end
        COPY_RD: begin
          r_latch <= bus.MemDataIn;
          r_src   <= r_src + 1'b1;
        end
        COPY_WR: begin
          r_dst <= r_dst + 1'b1;
          r_rem <= r_rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state plus port mux: passthrough by default, engine owns the port while busy.
  always_comb begin
    w_next         = r_state;
    bus.MemWriteEn = bus.CpuWriteEn;
    bus.MemReadEn  = bus.CpuReadEn;
    bus.MemAddress = bus.CpuAddress;
    bus.MemDataOut = bus.CpuDataIn;
    bus.CpuDataOut = bus.MemDataIn;
    bus.CpuStall   = 1'b0;
    bus.Busy       = 1'b0;
    bus.Done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          // Zero length or reserved opcode completes without touching memory.
          if ((bus.Len == '0) || bus.Op[1]) w_next = FINISH;
          else if (bus.Op == OP_FILL)       w_next = FILL;
          else                              w_next = COPY_RD;
        end
      end
      FILL: begin
        bus.MemWriteEn = 1'b1;
        bus.MemReadEn  = 1'b0;
        bus.MemAddress = r_dst;
        bus.MemDataOut = r_fill;
        bus.CpuDataOut = '0;
        bus.CpuStall   = w_cpu_req;
        bus.Busy       = 1'b1;
        if (r_rem == ADDR_W'(1)) w_next = FINISH;
      end
      COPY_RD: begin
        bus.MemWriteEn = 1'b0;
        bus.MemReadEn  = 1'b1;
        bus.MemAddress = r_src;
        bus.MemDataOut = '0;
        bus.CpuDataOut = '0;
        bus.CpuStall   = w_cpu_req;
        bus.Busy       = 1'b1;
        w_next         = COPY_WR;
      end
      COPY_WR: begin
        bus.MemWriteEn = 1'b1;
        bus.MemReadEn  = 1'b0;
        bus.MemAddress = r_dst;
        bus.MemDataOut = r_latch;
        bus.CpuDataOut = '0;
        bus.CpuStall   = w_cpu_req;
        bus.Busy       = 1'b1;
        w_next         = (r_rem == ADDR_W'(1)) ? FINISH : COPY_RD;
      end
      FINISH: begin
        bus.Done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// Bench for data_mem_dma with a behavioural 256x8 data memory on its port.
module tb_data_mem_dma;
  import data_mem_dma_pkg::*;

  localparam int K_LOAD = 0;
  localparam int K_DONE = 1;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } exp_t;

  logic Clk;
  logic Reset;
  logic [7:0] mem [256];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  data_mem_dma_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  data_mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory: synchronous write, combinational read, output parked at 0 when not read.
  always_ff @(posedge Clk) begin
    if (bus.MemWriteEn) mem[bus.MemAddress] <= bus.MemDataOut;
  end
  assign bus.MemDataIn = bus.MemReadEn ? mem[bus.MemAddress] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop(input int kind, input int act);
    exp_t e;
    if (sb.size() == 0 || sb[0].kind != kind) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got %0h with no matching expectation",
               (kind == K_DONE) ? "done" : "load", act);
    end else begin
      e = sb.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  // Monitor: Done pops the expected busy-cycle count, unstalled loads pop data.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        busy_cnt = 0;
      end else begin
        if (bus.Busy) busy_cnt++;
        if (bus.Done) begin
          pop(K_DONE, busy_cnt);
          busy_cnt = 0;
        end
        if (bus.CpuReadEn && !bus.CpuStall && !bus.Busy)
          pop(K_LOAD, int'(bus.CpuDataOut));
      end
    end
  end

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    @(posedge Clk); #2;
    bus.CpuWriteEn = 1'b1; bus.CpuAddress = a; bus.CpuDataIn = d;
    @(posedge Clk); #2;
    bus.CpuWriteEn = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d, input string name);
    @(posedge Clk); #2;
    bus.CpuReadEn = 1'b1; bus.CpuAddress = a;
    sb.push_back('{kind: K_LOAD, exp: int'(d), name: name});
    @(posedge Clk); #2;
    bus.CpuReadEn = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                     input logic [7:0] len, input logic [7:0] fill);
    @(posedge Clk); #2;
    bus.Start = 1'b1; bus.Op = op; bus.SrcAddr = src; bus.DstAddr = dst;
    bus.Len = len; bus.FillValue = fill;
    @(posedge Clk); #2;
    bus.Start = 1'b0;
  endtask

  task automatic expect_done(input int busy_cycles, input string name);
    sb.push_back('{kind: K_DONE, exp: busy_cycles, name: name});
  endtask

  initial begin
    Reset = 1'b0;
    bus.CpuWriteEn = 1'b0; bus.CpuReadEn = 1'b0; bus.CpuAddress = '0; bus.CpuDataIn = '0;
    bus.Start = 1'b0; bus.Op = '0; bus.SrcAddr = '0; bus.DstAddr = '0;
    bus.Len = '0; bus.FillValue = '0;
    #1;
    check("rst_busy",  bus.Busy, 0);
    check("rst_done",  bus.Done, 0);
    check("rst_stall", bus.CpuStall, 0);
    check("rst_memwe", bus.MemWriteEn, 0);
    @(posedge Clk); #2;
    Reset = 1'b1;

    // Passthrough store then load
    store(8'h10, 8'h5A);
    @(posedge Clk); #2;
    bus.CpuReadEn = 1'b1; bus.CpuAddress = 8'h10;
    sb.push_back('{kind: K_LOAD, exp: 32'h5A, name: "pass_load"});
    @(negedge Clk);
    check("pass_stall", bus.CpuStall, 0);
    check("pass_busy",  bus.Busy, 0);
    @(posedge Clk); #2;
    bus.CpuReadEn = 1'b0;

    // FILL 4 bytes of AA at 0x20; 0x24 must keep its preload
    store(8'h24, 8'h11);
    expect_done(4, "fill_busy_cycles");
    cmd(OP_FILL, 8'h00, 8'h20, 8'd4, 8'hAA);
    repeat (6) @(posedge Clk);
    load(8'h20, 8'hAA, "fill_20");
    load(8'h21, 8'hAA, "fill_21");
    load(8'h23, 8'hAA, "fill_23");
    load(8'h24, 8'h11, "fill_24_kept");

    // COPY across the FF->00 wrap
    store(8'hFE, 8'h01);
    store(8'hFF, 8'h02);
    store(8'h00, 8'h03);
    expect_done(6, "copy_busy_cycles");
    cmd(OP_COPY, 8'hFE, 8'h40, 8'd3, 8'h00);
    repeat (8) @(posedge Clk);
    load(8'h40, 8'h01, "copy_40");
    load(8'h41, 8'h02, "copy_41");
    load(8'h42, 8'h03, "copy_42");

    // Len=0 and reserved op: Done next cycle, no memory access, never busy
    expect_done(0, "len0_busy_cycles");
    cmd(OP_FILL, 8'h00, 8'h50, 8'd0, 8'hFF);
    @(negedge Clk);
    check("len0_done", bus.Done, 1);
    check("len0_en",   {bus.MemWriteEn, bus.MemReadEn}, 0);
    @(negedge Clk);
    check("len0_done_once", bus.Done, 0);
    expect_done(0, "rsv_busy_cycles");
    cmd(2'b10, 8'h00, 8'h50, 8'd5, 8'hFF);
    @(negedge Clk);
    check("rsv_done", bus.Done, 1);
    check("rsv_en",   {bus.MemWriteEn, bus.MemReadEn}, 0);
    check("rsv_busy", bus.Busy, 0);
    load(8'h50, 8'h00 | mem[8'h50], "rsv_50_untouched");

    // Core access during FILL is stalled; a second Start is ignored
    store(8'h90, 8'h12);
    store(8'h88, 8'h01);
    expect_done(8, "stall_busy_cycles");
    cmd(OP_FILL, 8'h00, 8'h80, 8'd8, 8'h55);
    bus.CpuWriteEn = 1'b1; bus.CpuAddress = 8'h90; bus.CpuDataIn = 8'hEE;
    @(negedge Clk);
    check("stall_wr", bus.CpuStall, 1);
    @(posedge Clk); #2;
    bus.CpuWriteEn = 1'b0;
    bus.CpuReadEn = 1'b1; bus.CpuAddress = 8'h80;
    @(negedge Clk);
    check("stall_rd",   bus.CpuStall, 1);
    check("stall_data", bus.CpuDataOut, 0);
    @(posedge Clk); #2;
    bus.CpuReadEn = 1'b0;
    cmd(OP_FILL, 8'h00, 8'h90, 8'd2, 8'h99);
    repeat (10) @(posedge Clk);
    load(8'h80, 8'h55, "stall_fill_80");
    load(8'h87, 8'h55, "stall_fill_87");
    load(8'h88, 8'h01, "stall_fill_88_kept");
    load(8'h90, 8'h12, "stall_target_kept");

    // Reset in the second FILL cycle aborts with no Done
    store(8'h60, 8'h01);
    store(8'h61, 8'h02);
    store(8'h62, 8'h03);
    cmd(OP_FILL, 8'h00, 8'h60, 8'd8, 8'h77);
    @(posedge Clk); #2;
    Reset = 1'b0;
    #1;
    check("abort_busy", bus.Busy, 0);
    check("abort_done", bus.Done, 0);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    load(8'h60, 8'h77, "abort_60_written");
    load(8'h61, 8'h02, "abort_61_kept");
    load(8'h62, 8'h03, "abort_62_kept");
    store(8'h70, 8'hC3);
    load(8'h70, 8'hC3, "abort_pass");

    repeat (3) @(posedge Clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_dma.md
Name: data_mem_dma

Overview:
- Upstream neighbour of the 256x8 data memory. Owns the memory's single port (WriteEn, ReadEn, DataAddress, DataIn) and passes the core's load/store path through when idle.
- Adds a small sequential engine that fills or copies a block of bytes without core involvement.
- Used for scratch-area clearing and buffer moves in the lab programs.
- Memory is an external instance; this block only drives its port and samples its combinational DataOut.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- CpuWriteEn  in  1  core store request.
- CpuReadEn  in  1  core load request.
- CpuAddress  in  ADDR_W  core address.
- CpuDataIn  in  DATA_W  core store data.
- CpuDataOut  out  DATA_W  load data returned to the core.
- CpuStall  out  1  core access refused this cycle because the engine is busy.
- Start  in  1  one-cycle command strobe.
- Op  in  2  00 FILL, 01 COPY, 1x reserved (treated as no-op).
- SrcAddr  in  ADDR_W  COPY source base.
- DstAddr  in  ADDR_W  FILL/COPY destination base.
- Len  in  ADDR_W  byte count; 0 means no transfer.
- FillValue  in  DATA_W  byte written by FILL.
- Busy  out  1  engine active.
- Done  out  1  one-cycle completion pulse.
- MemWriteEn  out  1  to memory WriteEn.
- MemReadEn  out  1  to memory ReadEn.
- MemAddress  out  ADDR_W  to memory DataAddress.
- MemDataOut  out  DATA_W  to memory DataIn.
- MemDataIn  in  DATA_W  from memory DataOut (combinational read).

Behaviour:
- States: IDLE, FILL, COPY_RD, COPY_WR, FINISH.
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - Busy=0, Done=0, CpuStall=0; MemWriteEn and MemReadEn follow the IDLE passthrough.
  - Internal counters and the copy latch are cleared to 0.
- IDLE:
  - The mem port is a combinational passthrough: MemWriteEn=CpuWriteEn, MemReadEn=CpuReadEn, MemAddress=CpuAddress, MemDataOut=CpuDataIn.
  - CpuDataOut=MemDataIn.
- Start accepted only in IDLE, on the posedge where Start=1. Inputs are latched into src, dst, remaining, op and fill registers.
  - Len=0 or reserved Op: go to FINISH; no memory access.
  - FILL: go to FILL. COPY: go to COPY_RD.
- FILL, one byte per cycle:
  - MemWriteEn=1, MemAddress=dst, MemDataOut=fill.
  - dst increments and remaining decrements each cycle.
  - When remaining==1 at the posedge, go to FINISH.
  - Total Busy cycles = Len.
- COPY, two cycles per byte:
  - COPY_RD: MemReadEn=1, MemAddress=src; MemDataIn is latched at the posedge; src increments.
  - COPY_WR: MemWriteEn=1, MemAddress=dst, MemDataOut=latch; dst increments, remaining decrements.
  - Return to COPY_RD, or go to FINISH after the last byte. Total Busy cycles = 2*Len.
- FINISH: Done=1 for exactly one cycle, Busy=0, passthrough active; next state is IDLE.
- Busy=1 in FILL, COPY_RD and COPY_WR only.
- While Busy:
  - Core requests are not forwarded: no core write reaches memory.
  - CpuStall=CpuWriteEn|CpuReadEn; CpuDataOut=0.
- Start while Busy or in FINISH is ignored; no queuing.
- Address arithmetic is modulo 2**ADDR_W: 8'hFF+1 wraps to 8'h00.
- Copy is strictly ascending and byte-at-a-time. Overlap with dst>src is defined: it replicates the source pattern. Overlap with dst<=src gives a correct move.
- MemReadEn=0 whenever no read is intended, so the memory output floats only when it is unused.
- Reset asserted mid-transfer aborts at once; bytes already written remain and no Done pulse is produced.

Decomposition:
- Package data_mem_dma_pkg holds:
  - the Op encoding constants (OP_FILL, OP_COPY);
  - the state encoding (IDLE, FILL, COPY_RD, COPY_WR, FINISH);
  - ADDR_W/DATA_W defaults.
- No sub-module: a single FSM with counters and the port mux.
- The bench instantiates this block together with the existing data memory.

Test Plan:
- Passthrough: in IDLE, core stores 8'h5A @8'h10 then loads @8'h10 -> CpuDataOut=8'h5A, CpuStall=0, Busy=0.
- FILL: Start, Op=00, DstAddr=8'h20, Len=4, FillValue=8'hAA -> Busy for 4 cycles, Done pulse on cycle 5, mem[20..23]=AA, mem[24] unchanged.
- COPY with wrap: preload mem[FE]=1, mem[FF]=2, mem[00]=3; Start, Op=01, Src=8'hFE, Dst=8'h40, Len=3 -> Busy 6 cycles, mem[40..42]=1,2,3.
- Len=0 and reserved Op=10 -> no MemWriteEn/MemReadEn asserted, Done pulse in the next cycle, Busy never 1.
- Core store during FILL (Len=8) -> CpuStall=1 in that cycle, target byte unchanged; second Start mid-transfer ignored, exactly one Done.
- Reset deasserted-low at cycle 2 of FILL Len=8 -> Busy=0 immediately, only the first bytes written, no Done; after release, passthrough works.
